// File: rtl/irq_pkg.sv
// Shared definitions for the interrupt priority controller.
//   irq_state_e  : service FSM states (IDLE -> REQ -> WAIT -> IDLE)
//   NUM_IRQ_DEF  : default number of interrupt sources
//   idx_onehot() : index to one-hot source mask
package irq_pkg;

  localparam int unsigned NUM_IRQ_DEF = 32;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT
  } irq_state_e;

  function automatic logic [NUM_IRQ_DEF-1:0] idx_onehot(input logic [4:0] idx);
    logic [NUM_IRQ_DEF-1:0] mask;
    mask      = '0;
    mask[idx] = 1'b1;
    return mask;
  endfunction

endpackage

// File: rtl/irq_arbiter.sv
// Combinational interrupt arbiter.
//   eff_i        : effective (enabled, pending) sources
//   last_grant_i : index of the most recent grant (round-robin origin)
//   valid_o      : at least one source is pending
//   winner_o     : selected source index
// ROUND_ROBIN=0 picks the lowest set index; ROUND_ROBIN=1 searches upward
// starting just after last_grant_i, wrapping from NUM_IRQ-1 to 0.
module irq_arbiter #(
  parameter int unsigned  NUM_IRQ     = 32,
  parameter bit           ROUND_ROBIN = 1'b0,
  localparam int unsigned IDX_W       = $clog2(NUM_IRQ)
) (
  input  logic [NUM_IRQ-1:0] eff_i,
  input  logic [IDX_W-1:0]   last_grant_i,
  output logic               valid_o,
  output logic [IDX_W-1:0]   winner_o
);

  always_comb begin
    int unsigned idx;
    valid_o  = 1'b0;
    winner_o = '0;
    idx      = 0;
    if (ROUND_ROBIN) begin
      // Offsets 1..NUM_IRQ visit every source once, ending at last_grant itself.
      for (int unsigned k = 1; k <= NUM_IRQ; k++) begin
        idx = int'(last_grant_i) + k;
        if (idx >= NUM_IRQ) idx = idx - NUM_IRQ;
        if (!valid_o && eff_i[IDX_W'(idx)]) begin
          valid_o  = 1'b1;
          winner_o = IDX_W'(idx);
        end
      end
    end else begin
      for (int unsigned i = 0; i < NUM_IRQ; i++) begin
        if (!valid_o && eff_i[i]) begin
          valid_o  = 1'b1;
          winner_o = IDX_W'(i);
        end
      end
    end
  end

endmodule

// File: rtl/irq_prio_controller.sv
// Interrupt priority controller for the RISC-V core.
//   clk_i       : core clock
//   rst_i       : asynchronous reset, active high
//   int_req_i   : raw peripheral requests
//   mie_i       : per-source enable
//   edge_mode_i : per-source 1 = rising-edge latched, 0 = level
//   int_rst_i   : completion strobe from the core (one cycle)
//   int_o       : one-cycle trap request pulse
//   int_fin_o   : one-hot completion pulse to the served source
//   mcause_o    : served source index, zero-extended
// One interrupt is in service at a time; a grant is never revoked.
module irq_prio_controller
  import irq_pkg::*;
#(
  parameter int unsigned  NUM_IRQ     = NUM_IRQ_DEF,
  parameter bit           ROUND_ROBIN = 1'b0,
  localparam int unsigned IDX_W       = $clog2(NUM_IRQ)
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [NUM_IRQ-1:0] int_req_i,
  input  logic [NUM_IRQ-1:0] mie_i,
  input  logic [NUM_IRQ-1:0] edge_mode_i,
  input  logic               int_rst_i,
  output logic               int_o,
  output logic [NUM_IRQ-1:0] int_fin_o,
  output logic [31:0]        mcause_o
);

  irq_state_e       state_q, state_d;
  logic [NUM_IRQ-1:0] req_q;
  logic [NUM_IRQ-1:0] pend_edge_q, pend_edge_d;
  logic [NUM_IRQ-1:0] eff;
  logic [IDX_W-1:0] cause_q;
  logic [IDX_W-1:0] last_grant_q;
  logic [IDX_W-1:0] winner;
  logic             arb_valid;
  logic             grant;
  logic             fin_en;
  logic [NUM_IRQ_DEF-1:0] fin_mask;

  assign eff = mie_i & ((edge_mode_i & pend_edge_q) | (~edge_mode_i & int_req_i));

  irq_arbiter #(
    .NUM_IRQ     (NUM_IRQ),
    .ROUND_ROBIN (ROUND_ROBIN)
  ) u_arbiter (
    .eff_i        (eff),
    .last_grant_i (last_grant_q),
    .valid_o      (arb_valid),
    .winner_o     (winner)
  );

  // A new rising edge in the completion cycle must survive the clear.
  assign pend_edge_d = (pend_edge_q & ~int_fin_o) | (int_req_i & ~req_q);

  assign fin_mask = idx_onehot(5'(cause_q));
  assign mcause_o = 32'(cause_q);

  always_comb begin
    state_d   = state_q;
    int_o     = 1'b0;
    fin_en    = 1'b0;
    grant     = 1'b0;
    int_fin_o = '0;
    case (state_q)
      IDLE: begin
        if (arb_valid) begin
          grant   = 1'b1;
          state_d = REQ;
        end
      end
      REQ: begin
        int_o   = 1'b1;
        state_d = WAIT;
      end
      WAIT: begin
        if (int_rst_i) begin
          fin_en  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (fin_en) int_fin_o = fin_mask[NUM_IRQ-1:0];
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      req_q        <= '0;
      pend_edge_q  <= '0;
      cause_q      <= '0;
      last_grant_q <= IDX_W'(NUM_IRQ - 1);
    end else begin
      state_q     <= state_d;
      req_q       <= int_req_i;
      pend_edge_q <= pend_edge_d;
      if (grant) begin
        cause_q      <= winner;
        last_grant_q <= winner;
      end
    end
  end

endmodule

// File: tb/tb_irq_prio_controller.sv
module tb_irq_prio_controller;

  logic        clk;
  logic        rst;
  logic [31:0] req, mie, edm;
  logic        irst;
  logic        int_f;
  logic [31:0] fin_f, mc_f;

  logic [31:0] req_r, mie_r, edm_r;
  logic        irst_r;
  logic        int_r;
  logic [31:0] fin_r, mc_r;

  int n_assert = 0;
  int n_fail   = 0;

  irq_prio_controller #(.NUM_IRQ(32), .ROUND_ROBIN(1'b0)) u_fix (
    .clk_i       (clk),
    .rst_i       (rst),
    .int_req_i   (req),
    .mie_i       (mie),
    .edge_mode_i (edm),
    .int_rst_i   (irst),
    .int_o       (int_f),
    .int_fin_o   (fin_f),
    .mcause_o    (mc_f)
  );

  irq_prio_controller #(.NUM_IRQ(32), .ROUND_ROBIN(1'b1)) u_rr (
    .clk_i       (clk),
    .rst_i       (rst),
    .int_req_i   (req_r),
    .mie_i       (mie_r),
    .edge_mode_i (edm_r),
    .int_rst_i   (irst_r),
    .int_o       (int_r),
    .int_fin_o   (fin_r),
    .mcause_o    (mc_r)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    int n;
    logic [31:0] rr_seq [5];
    rr_seq = '{0, 1, 3, 0, 1};

    rst = 1'b1; req = '0; mie = '0; edm = '0; irst = 1'b0;
    req_r = '0; mie_r = '0; edm_r = '0; irst_r = 1'b0;
    #12;
    chk("rst_int", {31'd0, int_f}, 32'd0);
    chk("rst_fin", fin_f, 32'd0);
    chk("rst_mcause", mc_f, 32'd0);
    chk("rst_rr_mcause", mc_r, 32'd0);
    tick();
    rst = 1'b0;
    tick();

    // Round robin: sources 0, 1, 3 held high.
    mie_r = '1; req_r = 32'h0000_000B;
    for (int s = 0; s < 5; s++) begin
      n = 0;
      while (int_r !== 1'b1 && n < 10) begin
        tick();
        n++;
      end
      chk("rr_int", {31'd0, int_r}, 32'd1);
      chk("rr_mcause", mc_r, rr_seq[s]);
      tick();
      irst_r = 1'b1;
      #1;
      chk("rr_fin", fin_r, 32'd1 << rr_seq[s]);
      tick();
      irst_r = 1'b0;
    end
    req_r = '0;

    // Fixed priority: level 5 and 2 together.
    mie = '1; edm = '0; req = 32'h0000_0024;
    tick();
    chk("fp_int1", {31'd0, int_f}, 32'd1);
    chk("fp_mc1", mc_f, 32'd2);
    tick();
    chk("fp_wait_int", {31'd0, int_f}, 32'd0);
    chk("fp_wait_mc", mc_f, 32'd2);
    irst = 1'b1; req = 32'h0000_0020;
    #1;
    chk("fp_fin1", fin_f, 32'h0000_0004);
    tick();
    irst = 1'b0;
    chk("fp_idle_int", {31'd0, int_f}, 32'd0);
    chk("fp_idle_mc", mc_f, 32'd2);
    tick();
    chk("fp_int2", {31'd0, int_f}, 32'd1);
    chk("fp_mc2", mc_f, 32'd5);
    tick();
    irst = 1'b1; req = '0;
    #1;
    chk("fp_fin2", fin_f, 32'h0000_0020);
    tick();
    irst = 1'b0;

    // Masking: source 9 requesting but disabled.
    mie = ~(32'd1 << 9); req = 32'd1 << 9;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("mask_int", {31'd0, int_f}, 32'd0);
    end
    irst = 1'b1;
    #1;
    chk("idle_rst_fin", fin_f, 32'd0);
    tick();
    irst = 1'b0;
    mie = '1;
    tick();
    chk("m9_int", {31'd0, int_f}, 32'd1);
    chk("m9_mc", mc_f, 32'd9);
    tick();
    mie = ~(32'd1 << 9); req = '0;
    tick();
    chk("m9_wait_int", {31'd0, int_f}, 32'd0);
    irst = 1'b1;
    #1;
    chk("m9_fin", fin_f, 32'd1 << 9);
    tick();
    irst = 1'b0; mie = '1;

    // Edge latching: 7 pulses while 4 is in service.
    edm = 32'd1 << 7; req = 32'd1 << 4;
    tick();
    chk("e4_int", {31'd0, int_f}, 32'd1);
    chk("e4_mc", mc_f, 32'd4);
    tick();
    req = (32'd1 << 4) | (32'd1 << 7);
    tick();
    req = 32'd1 << 4;
    tick();
    tick();
    irst = 1'b1; req = '0;
    #1;
    chk("e4_fin", fin_f, 32'd1 << 4);
    tick();
    irst = 1'b0;
    chk("e7_idle_int", {31'd0, int_f}, 32'd0);
    tick();
    chk("e7_int", {31'd0, int_f}, 32'd1);
    chk("e7_mc", mc_f, 32'd7);
    tick();
    irst = 1'b1; req = 32'd1 << 7;
    #1;
    chk("e7_fin", fin_f, 32'd1 << 7);
    tick();
    irst = 1'b0; req = '0;
    tick();
    chk("e7b_int", {31'd0, int_f}, 32'd1);
    chk("e7b_mc", mc_f, 32'd7);
    tick();
    irst = 1'b1;
    #1;
    chk("e7b_fin", fin_f, 32'd1 << 7);
    tick();
    irst = 1'b0;
    tick();
    chk("e7_done_int", {31'd0, int_f}, 32'd0);
    tick();
    chk("e7_done_int2", {31'd0, int_f}, 32'd0);

    // Reset during WAIT for source 3, with edge 7 pending.
    edm = 32'd1 << 7; req = 32'd1 << 3;
    tick();
    chk("r3_int", {31'd0, int_f}, 32'd1);
    chk("r3_mc", mc_f, 32'd3);
    tick();
    req = (32'd1 << 3) | (32'd1 << 7);
    tick();
    req = 32'd1 << 3;
    tick();
    rst = 1'b1; req = '0; irst = 1'b1;
    #1;
    chk("r3_rst_int", {31'd0, int_f}, 32'd0);
    chk("r3_rst_fin", fin_f, 32'd0);
    chk("r3_rst_mc", mc_f, 32'd0);
    tick();
    rst = 1'b0; irst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("r3_post_int", {31'd0, int_f}, 32'd0);
      chk("r3_post_fin", fin_f, 32'd0);
    end
    irst = 1'b1;
    #1;
    chk("r3_post_rst_fin", fin_f, 32'd0);
    tick();
    irst = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/irq_prio_controller.md
Name: irq_prio_controller

Overview:
- Parametrised interrupt controller for the RISC-V core, with NUM_IRQ sources.
- Each source is either level-sensitive or rising-edge-latched, selected per source.
- Arbitration is fixed-priority or round-robin; only one interrupt is in service at a time.
- Claim/complete handshake with the core's CSR/trap logic:
  - int_o pulse starts a trap.
  - int_rst_i (mret/complete) ends service.
  - int_fin_o tells the served peripheral its request was consumed.

Parameters:
- NUM_IRQ, 32, number of interrupt sources (2..32).
- ROUND_ROBIN, 0, 0 = fixed priority (lowest index wins); 1 = rotating priority starting after the last grant.
- IDX_W, $clog2(NUM_IRQ), width of the source index (derived, not overridden).

Ports:
- clk_i  in  1  core clock.
- rst_i  in  1  asynchronous reset, active high.
- int_req_i  in  NUM_IRQ  raw interrupt requests from peripherals.
- mie_i  in  NUM_IRQ  per-source enable (from the mie CSR).
- edge_mode_i  in  NUM_IRQ  per source: 1 = rising-edge latched, 0 = level.
- int_rst_i  in  1  completion strobe from the core; one cycle.
- int_o  out  1  one-cycle trap request pulse to the core.
- int_fin_o  out  NUM_IRQ  one-hot completion pulse to the served source.
- mcause_o  out  32  served source index, zero-extended to 32 bits.

Behaviour:
- Reset: all registers clear asynchronously; int_o=0, int_fin_o=0, mcause_o=0, FSM=IDLE.
  - Also cleared: edge pending, req_q (previous request sample), and last_grant (= NUM_IRQ-1, so round-robin starts at index 0).
- Edge capture: on each edge, req_q <= int_req_i.
  - pend_edge[i] is set when int_req_i[i] & ~req_q[i].
  - pend_edge[i] is cleared by int_fin_o[i].
  - Set wins over clear in the same cycle.
- Effective pending: eff[i] = mie_i[i] & (edge_mode_i[i] ? pend_edge[i] : int_req_i[i]).
- Arbiter (combinational):
  - Fixed mode: lowest set index of eff.
  - Round-robin mode: first set index searching last_grant+1 upward, wrapping from NUM_IRQ-1 to 0.
- FSM states:
  - IDLE: if |eff then latch winner into cause_q, set last_grant <= winner, go to REQ; else stay.
  - REQ: int_o=1 for exactly this cycle; go to WAIT unconditionally.
  - WAIT: hold cause_q. On int_rst_i: int_fin_o = one-hot(cause_q) for that cycle, then go to IDLE.
- int_rst_i is ignored in IDLE and REQ; no int_fin_o is produced in those states.
- mcause_o = {zeros, cause_q}. It holds its value from REQ through WAIT and keeps the last served index in IDLE.
- A grant is not revoked by later changes:
  - mie_i or int_req_i dropping during REQ/WAIT does not cancel the service.
  - int_fin_o still pulses at completion.
- Back-to-back service: the earliest next grant is the cycle after WAIT→IDLE, i.e. IDLE holds at least one cycle between services.
- Latency:
  - Level source: request sampled high in IDLE at edge k → int_o high in the cycle after edge k.
  - Edge source: rising edge sampled at edge k → pend_edge set at k → int_o high after edge k+1.
- Level sources are not latched: a level request dropped before the IDLE grant is lost.
- Edges arriving during WAIT stay pending and are served afterwards.
- Unused upper mcause bits are always 0.

Decomposition:
- Package irq_pkg holds:
  - the irq_state_e enum (IDLE, REQ, WAIT);
  - the default NUM_IRQ constant;
  - a function computing the one-hot mask from an index.
- Sub-module irq_arbiter (combinational): inputs eff and last_grant plus the ROUND_ROBIN parameter; outputs valid and the winner index.
- The edge capture, FSM and registers stay in irq_prio_controller.

Test Plan:
- Reset mid-WAIT: serving source 3, assert rst_i → int_o, int_fin_o and mcause_o go to 0 immediately; pend_edge clears; no int_fin_o afterwards.
- Fixed priority: mie=all ones, level sources 5 and 2 high together in IDLE → int_o pulse with mcause_o=2. After int_rst_i: int_fin_o=0x4, then a new pulse with mcause_o=5.
- Round robin (ROUND_ROBIN=1): sources 0, 1 and 3 held high; complete each service → mcause_o sequence 0, 1, 3, 0, 1.
- Edge latching:
  - Source 7 in edge mode pulses high for one cycle while source 4 is in WAIT. After completion → mcause_o=7.
  - A second rising edge on 7 in the same cycle as its int_fin_o keeps it pending → it is served again.
- Masking and handshake:
  - mie_i[9]=0 with int_req_i[9]=1 → int_o stays 0 for 20 cycles.
  - int_rst_i pulsed in IDLE → int_fin_o stays 0.
  - mie_i[9] cleared during WAIT → int_fin_o=1<<9 still issued at completion.
